rptr_ctrl: RTL and testbench
============================

// Module: rptr_ctrl
// PURPOSE
//  Read-side pointer/flag controller of the async FIFO on the JTAG path; read-domain counterpart of the write pointer.
//  Keeps the binary read address for the dual-port memory and publishes a registered Gray read pointer.
//  The write side synchronizes that pointer into wclk for its full logic.
//  Takes the 2-flop-synchronized Gray write pointer; produces empty, occupancy, almost_empty and a sticky underflow flag.
// PARAMETERS
//  ADDR_WIDTH  32  pointer/address width; memory depth 2**ADDR_WIDTH, one slot unused; must equal writer's ADDR_WIDTH
//  AE_THRESH   1   almost_empty asserts when rcount <= AE_THRESH
// PORTS
//  rclk          in   1           read-domain clock
//  r_nrst        in   1           async active-low reset, rclk domain
//  rinc          in   1           read request; pops one entry when !empty
//  sync_wptr     in   ADDR_WIDTH  Gray write pointer, already 2-flop synced into rclk
//  clr_err       in   1           clears underflow
//  raddr         out  ADDR_WIDTH  binary read address to memory
//  rptr          out  ADDR_WIDTH  registered Gray read pointer to write-domain synchronizer
//  empty         out  1           no readable entry
//  almost_empty  out  1           rcount <= AE_THRESH
//  rcount        out  ADDR_WIDTH  entries available (read-domain view, may lag writer)
//  underflow     out  1           sticky: rinc seen while empty
// BEHAVIOUR
//  - Reset (async, r_nrst=0, any time incl. mid-read): raddr=0, rptr=0, underflow=0.
//    Flags then follow from raddr=0 and sync_wptr; empty=1 while sync_wptr=0.
//  - Writer's Gray pointer is decoded locally to binary: wbin = gray2bin(sync_wptr).
//  - empty = (raddr == wbin); combinational from raddr flop and synced input, 0-cycle latency.
//  - nxt_raddr = raddr + 1 (mod 2**ADDR_WIDTH) when rinc && !empty, else raddr.
//    raddr <= nxt_raddr each rclk.
//  - rptr <= bin2gray(nxt_raddr): a flop output, never combinational; invariant rptr == bin2gray(raddr).
//    Exactly one bit toggles per pop, including the wrap from all-ones to 0.
//  - rcount = (wbin - raddr) mod 2**ADDR_WIDTH, unsigned ADDR_WIDTH-bit wrap arithmetic; max value 2**ADDR_WIDTH-1.
//  - almost_empty = (rcount <= AE_THRESH); implies empty-or-nearly; combinational.
//  - Read data is valid at memory address raddr while !empty; a pop advances raddr at the next rclk edge.
//  - Pop/flags follow raddr and sync_wptr with 0 cycles added:
//    - empty deasserts the cycle sync_wptr moves past raddr;
//    - a pop of the last entry asserts empty in the following cycle.
//  - Underflow:
//    - rinc && empty: raddr/rptr unchanged, underflow <= 1.
//    - clr_err alone: underflow <= 0.
//    - Set wins over clear when both occur in the same cycle.
//  - sync_wptr may jump by >1 (writer faster); rcount/empty remain correct since decode is absolute, not incremental.
// STRUCTURE
//  - Reuse flex_bin2gray: #(.bin2gray(1)) on nxt_raddr -> rptr D-input; #(.bin2gray(0)) on sync_wptr -> wbin.
//  - No new sub-module; no FSM; flops: raddr, rptr, underflow.
//  - jtag_types_pkg: no additions; widths are parameter-driven.
//  - The rclk->wclk synchronizer for rptr lives outside this block.
// TESTING (ADDR_WIDTH=3, AE_THRESH=1, depth 8, 7 usable)
//  1. Reset: sync_wptr=0, drop r_nrst mid-cycle -> raddr=0, rptr=000, empty=1, rcount=0, underflow=0 without waiting for rclk.
//  2. Drain: sync_wptr=gray(3)=010, rinc held 4 cycles -> raddr 0,1,2,3,3; rcount 3,2,1,0,0; empty=1 from raddr=3; 4th rinc sets underflow=1, raddr stays 3.
//  3. Wrap: raddr=7, sync_wptr=gray(1)=001 -> rcount=2; pop -> raddr=0, rptr=000; pop -> raddr=1, empty=1.
//  4. almost_empty: sync_wptr=gray(4), raddr=0 -> rcount=4, almost_empty=0; pops -> almost_empty=1 at rcount=1, stays 1 at rcount=0.
//  5. Gray check: step writer 0..7..0 and read everything over 2 laps -> every rptr change has Hamming distance 1 and rptr==bin2gray(raddr) every cycle.
//  6. Error clear: rinc on empty with clr_err=1 same cycle -> underflow=1; next cycle clr_err=1, rinc=0 -> underflow=0.

Source files
------------

// File: rtl/rptr_ctrl_pkg.sv
// rptr_ctrl_pkg: default geometry shared by the read-pointer controller and its bench
package rptr_ctrl_pkg;
    localparam int RPTR_ADDR_WIDTH = 32;
    localparam int RPTR_AE_THRESH  = 1;
endpackage

// File: rtl/flex_bin2gray.sv
// flex_bin2gray: binary->Gray when bin2gray=1, Gray->binary otherwise
module flex_bin2gray #(
    parameter int WIDTH    = 32,
    parameter bit bin2gray = 1'b1
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] g2b;
    // each binary bit is the parity of all Gray bits at or above it
    for (genvar i = 0; i < WIDTH; i++) begin : g_dec
        assign g2b[i] = ^din[WIDTH-1:i];
    end
    assign dout = bin2gray ? (din ^ (din >> 1)) : g2b;
endmodule

// File: rtl/rptr_ctrl.sv
// rptr_ctrl: async FIFO read-side pointer, Gray publish and empty/occupancy/underflow flags
module rptr_ctrl
    import rptr_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = RPTR_ADDR_WIDTH,
    parameter int AE_THRESH  = RPTR_AE_THRESH
) (
    input  logic                  rclk,
    input  logic                  r_nrst,
    input  logic                  rinc,
    input  logic [ADDR_WIDTH-1:0] sync_wptr,
    input  logic                  clr_err,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH-1:0] rptr,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH-1:0] rcount,
    output logic                  underflow
);
    logic [ADDR_WIDTH-1:0] wbin;
    logic [ADDR_WIDTH-1:0] nxt_raddr;
    logic [ADDR_WIDTH-1:0] nxt_rptr;

    flex_bin2gray #(.WIDTH(ADDR_WIDTH), .bin2gray(1'b0)) u_wptr_dec (.din(sync_wptr), .dout(wbin));
    flex_bin2gray #(.WIDTH(ADDR_WIDTH), .bin2gray(1'b1)) u_rptr_enc (.din(nxt_raddr), .dout(nxt_rptr));

    // absolute decode keeps flags right even when the writer jumps several slots
    assign empty        = (raddr == wbin);
    assign rcount       = wbin - raddr;
    assign almost_empty = (rcount <= ADDR_WIDTH'(AE_THRESH));
    assign nxt_raddr    = raddr + ADDR_WIDTH'(rinc && !empty);

    always_ff @(posedge rclk or negedge r_nrst) begin
        if (!r_nrst) begin
            raddr     <= '0;
            rptr      <= '0;
            underflow <= 1'b0;
        end else begin
            raddr     <= nxt_raddr;
            rptr      <= nxt_rptr;
            underflow <= (rinc && empty) ? 1'b1 : clr_err ? 1'b0 : underflow;
        end
    end
endmodule

// File: tb/tb_rptr_ctrl.sv
// tb_rptr_ctrl: randomized check of rptr_ctrl (ADDR_WIDTH=3) against an occupancy-count model
module tb_rptr_ctrl;
    logic       rclk = 1'b0;
    logic       r_nrst = 1'b0;
    logic       rinc = 1'b0;
    logic       clr_err = 1'b0;
    logic [2:0] sync_wptr = 3'd0;
    logic [2:0] raddr, rptr, rcount;
    logic       empty, almost_empty, underflow;

    int n_vec = 0;
    int n_err = 0;
    int wr_total = 0;
    int rd_total = 0;
    bit uf_m = 1'b0;
    logic [2:0] gray_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    rptr_ctrl #(.ADDR_WIDTH(3), .AE_THRESH(1)) dut (
        .rclk(rclk), .r_nrst(r_nrst), .rinc(rinc), .sync_wptr(sync_wptr), .clr_err(clr_err),
        .raddr(raddr), .rptr(rptr), .empty(empty), .almost_empty(almost_empty),
        .rcount(rcount), .underflow(underflow)
    );

    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        int occ = wr_total - rd_total;
        chk({tag, ".raddr"}, 32'(raddr), 32'(rd_total % 8));
        chk({tag, ".rptr"}, 32'(rptr), 32'(gray_tab[rd_total % 8]));
        chk({tag, ".rcount"}, 32'(rcount), 32'(occ));
        chk({tag, ".empty"}, 32'(empty), 32'(occ == 0));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(occ <= 1));
        chk({tag, ".uflow"}, 32'(underflow), 32'(uf_m));
    endtask

    // one rclk: writer advances by adv entries, read request/clear driven, then the edge is modelled
    task automatic step(input bit ri, input bit ce, input int adv);
        logic [2:0] prev;
        @(negedge rclk);
        wr_total += adv;
        sync_wptr = gray_tab[wr_total % 8];
        rinc = ri;
        clr_err = ce;
        #1 chk_all("pre");
        prev = rptr;
        @(posedge rclk);
        if (ri && wr_total == rd_total) uf_m = 1'b1;
        else begin
            if (ce) uf_m = 1'b0;
            if (ri) rd_total++;
        end
        #1 chk_all("post");
        if (prev != rptr) chk("hamming", 32'($countones(prev ^ rptr)), 32'd1);
    endtask

    initial begin
        #12 r_nrst = 1'b1;
        // some traffic so reset has state to clear
        step(0, 0, 5);
        step(1, 0, 0);
        step(1, 0, 0);
        // async reset mid-cycle, checked before any rclk edge
        @(posedge rclk);
        #2 sync_wptr = 3'd0;
        rinc = 1'b0;
        wr_total = 0;
        rd_total = 0;
        uf_m = 1'b0;
        #1 r_nrst = 1'b0;
        #1 chk_all("reset");
        @(negedge rclk);
        r_nrst = 1'b1;
        // drain of three entries then underflow
        step(0, 0, 3);
        repeat (4) step(1, 0, 0);
        step(0, 1, 0);
        // wrap: bring raddr to 7 then pop across the boundary
        step(0, 0, 4);
        repeat (4) step(1, 0, 0);
        step(0, 0, 2);
        repeat (3) step(1, 0, 0);
        // almost_empty thresholds
        step(0, 0, 4);
        repeat (5) step(1, 0, 0);
        // two laps of single-step writes and reads
        repeat (16) step(1, 0, 1);
        step(1, 0, 0);
        // set wins over clear, then clear alone
        step(1, 1, 0);
        step(0, 1, 0);
        // random traffic with writer jumps
        repeat (1500) begin
            int occ = wr_total - rd_total;
            int adv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7 - occ)) : 0;
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), adv);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
